// File: rtl/iob_intr_sched.sv
`default_nettype none
// ============================================================================
//  Module      : iob_intr_sched
//  Description : Round-robin scheduler that shares the IOB NoC output port
//                between NUM_REQ interrupt sources. Each grant becomes one
//                2-flit interrupt packet (header, payload). Packets are
//                never interleaved.
//  Revision    : 1.0 - initial release
// ============================================================================

`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 64
`endif
`ifndef NOC_FBITS_L1
`define NOC_FBITS_L1 4'b0000
`endif
`ifndef MSG_TYPE_INTERRUPT
`define MSG_TYPE_INTERRUPT 8'd32
`endif
`ifndef MSG_DST_X
`define MSG_DST_X 49:42
`endif
`ifndef MSG_DST_Y
`define MSG_DST_Y 41:34
`endif

module iob_intr_sched #(
    parameter int NUM_REQ = 4,
    parameter int X_TILES = 8,
    parameter int Y_TILES = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_val,
    output logic [NUM_REQ-1:0]          req_rdy,
    input  logic [NUM_REQ*32-1:0]       req_tile,
    input  logic [NUM_REQ*64-1:0]       req_data,
    output logic                        noc_out_val,
    input  logic                        noc_out_rdy,
    output logic [`NOC_DATA_WIDTH-1:0]  noc_out_data,
    output logic                        err_bad_tile,
    output logic [15:0]                 pkt_cnt
);

    localparam int          C_PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [31:0] C_NUM_TILES = 32'(X_TILES * Y_TILES);
    localparam logic [31:0] C_X_TILES   = 32'(X_TILES);

    localparam logic [1:0] C_IDLE = 2'd0;
    localparam logic [1:0] C_HDR  = 2'd1;
    localparam logic [1:0] C_PLD  = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [C_PTR_W-1:0]  r_rr_ptr;
    logic [C_PTR_W-1:0]  r_gnt;
    logic [7:0]          r_dst_x;
    logic [7:0]          r_dst_y;
    logic [63:0]         r_data;
    logic                r_err;
    logic [15:0]         r_pkt_cnt;

    logic                w_any;
    logic [C_PTR_W-1:0]  w_gnt;
    logic [C_PTR_W:0]    w_idx;
    logic [31:0]         w_tile;
    logic [63:0]         w_data;
    logic                w_tile_ok;
    logic                w_accept;
    logic [63:0]         w_hdr;
    logic [63:0]         w_pld;

    // Wrap-around increment of a requester index
    function automatic logic [C_PTR_W-1:0] ptr_inc(input logic [C_PTR_W-1:0] p);
        return (p == C_PTR_W'(NUM_REQ - 1)) ? '0 : p + 1'b1;
    endfunction

    // Round-robin pick: first valid requester at or after r_rr_ptr. The loop
    // runs backwards so the closest candidate is the last one assigned.
    always_comb begin
        w_any = 1'b0;
        w_gnt = '0;
        w_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = {1'b0, r_rr_ptr} + (C_PTR_W + 1)'(k);
            if (w_idx >= (C_PTR_W + 1)'(NUM_REQ)) begin
                w_idx = w_idx - (C_PTR_W + 1)'(NUM_REQ);
            end
            if (req_val[w_idx[C_PTR_W-1:0]]) begin
                w_any = 1'b1;
                w_gnt = w_idx[C_PTR_W-1:0];
            end
        end
    end

    assign w_tile    = req_tile[int'(w_gnt) * 32 +: 32];
    assign w_data    = req_data[int'(w_gnt) * 64 +: 64];
    assign w_tile_ok = (w_tile < C_NUM_TILES);
    assign w_accept  = (r_state == C_IDLE) && w_any;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= C_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a bad tile id is dropped without leaving IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            C_IDLE:  if (w_any && w_tile_ok) w_state_nxt = C_HDR;
            C_HDR:   if (noc_out_rdy)        w_state_nxt = C_PLD;
            C_PLD:   if (noc_out_rdy)        w_state_nxt = C_IDLE;
            default:                         w_state_nxt = C_IDLE;
        endcase
    end

    // Flit images built from the fields latched at grant time, so they stay
    // stable for as long as the NoC applies backpressure
    always_comb begin
        w_hdr = {14'b0, 5'b0, 3'b0, 8'b0, `NOC_FBITS_L1, 8'd1, `MSG_TYPE_INTERRUPT, 14'b0};
        w_hdr[`MSG_DST_X] = r_dst_x;
        w_hdr[`MSG_DST_Y] = r_dst_y;
        w_pld = {r_data[63:16], 7'b0, r_data[8:0]};
    end

    // FSM outputs: grant strobe in IDLE, flits in HDR/PLD
    always_comb begin
        req_rdy      = '0;
        noc_out_val  = 1'b0;
        noc_out_data = '0;
        case (r_state)
            C_IDLE: begin
                if (w_any) req_rdy = NUM_REQ'(1) << w_gnt;
            end
            C_HDR: begin
                noc_out_val  = 1'b1;
                noc_out_data = `NOC_DATA_WIDTH'(w_hdr);
            end
            C_PLD: begin
                noc_out_val  = 1'b1;
                noc_out_data = `NOC_DATA_WIDTH'(w_pld);
            end
            default: begin
                noc_out_val  = 1'b0;
            end
        endcase
    end

    // Grant capture, round-robin pointer, error pulse and packet counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr  <= '0;
            r_gnt     <= '0;
            r_dst_x   <= '0;
            r_dst_y   <= '0;
            r_data    <= '0;
            r_err     <= 1'b0;
            r_pkt_cnt <= '0;
        end else begin
            r_err <= w_accept && !w_tile_ok;
            if (w_accept) begin
                r_gnt   <= w_gnt;
                r_dst_x <= 8'(w_tile % C_X_TILES);
                r_dst_y <= 8'(w_tile / C_X_TILES);
                r_data  <= w_data;
                if (!w_tile_ok) r_rr_ptr <= ptr_inc(w_gnt);
            end
            if (r_state == C_PLD && noc_out_rdy) begin
                r_rr_ptr <= ptr_inc(r_gnt);
                if (r_pkt_cnt != 16'hFFFF) r_pkt_cnt <= r_pkt_cnt + 16'd1;
            end
        end
    end

    assign err_bad_tile = r_err;
    assign pkt_cnt      = r_pkt_cnt;

endmodule
`default_nettype wire

// File: tb/tb_iob_intr_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_iob_intr_sched
//  Description : Self-checking bench for iob_intr_sched: table of single
//                requests plus directed round-robin, bad-tile, backpressure,
//                reset-in-packet and counter-saturation sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_iob_intr_sched;

    localparam int NUM_REQ = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NUM_REQ-1:0]     req_val;
    logic [NUM_REQ-1:0]     req_rdy;
    logic [NUM_REQ*32-1:0]  req_tile;
    logic [NUM_REQ*64-1:0]  req_data;
    logic                   noc_out_val;
    logic                   noc_out_rdy;
    logic [63:0]            noc_out_data;
    logic                   err_bad_tile;
    logic [15:0]            pkt_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    iob_intr_sched #(.NUM_REQ(NUM_REQ), .X_TILES(8), .Y_TILES(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_val      (req_val),
        .req_rdy      (req_rdy),
        .req_tile     (req_tile),
        .req_data     (req_data),
        .noc_out_val  (noc_out_val),
        .noc_out_rdy  (noc_out_rdy),
        .noc_out_data (noc_out_data),
        .err_bad_tile (err_bad_tile),
        .pkt_cnt      (pkt_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          src;
        logic [31:0] tile;
        logic [63:0] data;
        bit          bad;
        logic [7:0]  x;
        logic [7:0]  y;
        logic [63:0] pld;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Header: X at [49:42], Y at [41:34], length 1 at [29:22], type 32 at [21:14]
    function automatic logic [63:0] hdr(input logic [7:0] x, input logic [7:0] y);
        return (64'(x) << 42) | (64'(y) << 34) | (64'd1 << 22) | (64'd32 << 14);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int s, input logic [31:0] t, input logic [63:0] d);
        req_tile[s*32 +: 32] = t;
        req_data[s*64 +: 64] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_val = '0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    // One full packet from source s with the NoC always ready
    task automatic send(input int s);
        req_val = NUM_REQ'(1) << s;
        #1;
        chk("send_rdy", 64'(req_rdy), 64'(NUM_REQ'(1) << s));
        cyc();
        req_val = '0;
        cyc();
        cyc();
    endtask

    initial begin
        int exp_cnt;
        int g;

        vecs[0] = '{0, 32'd0,          64'h1234_5678_9ABC_0101, 1'b0, 8'd0, 8'd0, 64'h1234_5678_9ABC_0101};
        vecs[1] = '{1, 32'd9,          64'h0000_0000_0000_0000, 1'b0, 8'd1, 8'd1, 64'h0000_0000_0000_0000};
        vecs[2] = '{2, 32'd63,         64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 8'd7, 8'd7, 64'hFFFF_FFFF_FFFF_01FF};
        vecs[3] = '{3, 32'd64,         64'h5555_5555_5555_5555, 1'b1, 8'd0, 8'd0, 64'h0};
        vecs[4] = '{0, 32'hFFFF_FFFF,  64'h1111_2222_3333_4444, 1'b1, 8'd0, 8'd0, 64'h0};
        vecs[5] = '{1, 32'd10,         64'hDEAD_BEEF_CAFE_FFFF, 1'b0, 8'd2, 8'd1, 64'hDEAD_BEEF_CAFE_01FF};

        req_tile    = '0;
        req_data    = '0;
        noc_out_rdy = 1'b1;
        do_reset();

        // Reset state
        #1;
        chk("rst_req_rdy", 64'(req_rdy), 64'd0);
        chk("rst_val", 64'(noc_out_val), 64'd0);
        chk("rst_data", noc_out_data, 64'd0);
        chk("rst_err", 64'(err_bad_tile), 64'd0);
        chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);

        // Table of single requests
        exp_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            set_src(vecs[i].src, vecs[i].tile, vecs[i].data);
            req_val = NUM_REQ'(1) << vecs[i].src;
            #1;
            chk("vec_grant", 64'(req_rdy), 64'(NUM_REQ'(1) << vecs[i].src));
            cyc();
            req_val = '0;
            #1;
            if (vecs[i].bad) begin
                chk("vec_bad_val", 64'(noc_out_val), 64'd0);
                chk("vec_bad_err", 64'(err_bad_tile), 64'd1);
                cyc();
                chk("vec_bad_err_end", 64'(err_bad_tile), 64'd0);
            end else begin
                chk("vec_hdr_val", 64'(noc_out_val), 64'd1);
                chk("vec_hdr", noc_out_data, hdr(vecs[i].x, vecs[i].y));
                chk("vec_hdr_err", 64'(err_bad_tile), 64'd0);
                cyc();
                chk("vec_pld_val", 64'(noc_out_val), 64'd1);
                chk("vec_pld", noc_out_data, vecs[i].pld);
                cyc();
                exp_cnt++;
                chk("vec_idle_val", 64'(noc_out_val), 64'd0);
                chk("vec_idle_data", noc_out_data, 64'd0);
                chk("vec_pkt_cnt", 64'(pkt_cnt), 64'(exp_cnt));
            end
        end

        // All sources valid continuously: order 0,1,2,3,0 at 3 cycles/packet
        do_reset();
        for (int s = 0; s < NUM_REQ; s++) begin
            set_src(s, 32'(s), 64'(s + 1) << 48);
        end
        req_val = 4'hF;
        #1;
        for (int p = 0; p < 5; p++) begin
            g = p % NUM_REQ;
            chk("rr_grant", 64'(req_rdy), 64'(NUM_REQ'(1) << g));
            cyc();
            chk("rr_hdr", noc_out_data, hdr(8'(g), 8'd0));
            chk("rr_hdr_rdy0", 64'(req_rdy), 64'd0);
            cyc();
            chk("rr_pld", noc_out_data, 64'(g + 1) << 48);
            chk("rr_pld_rdy0", 64'(req_rdy), 64'd0);
            cyc();
        end
        chk("rr_pkt_cnt", 64'(pkt_cnt), 64'd5);

        // Bad tile on src0 while src1 waits: drop, pulse, then src1 granted
        do_reset();
        set_src(0, 32'd64, 64'h0);
        set_src(1, 32'd3, 64'hABCD_0000_0000_0000);
        req_val = 4'b0011;
        #1;
        chk("bad_grant0", 64'(req_rdy), 64'd1);
        cyc();
        req_val = 4'b0010;
        #1;
        chk("bad_noflit", 64'(noc_out_val), 64'd0);
        chk("bad_err", 64'(err_bad_tile), 64'd1);
        chk("bad_next_grant", 64'(req_rdy), 64'd2);
        cyc();
        req_val = '0;
        chk("bad_next_hdr", noc_out_data, hdr(8'd3, 8'd0));
        chk("bad_err_end", 64'(err_bad_tile), 64'd0);
        cyc();
        cyc();

        // Backpressure in HDR then PLD; src0 waiting must not see req_rdy
        noc_out_rdy = 1'b0;
        set_src(2, 32'd5, 64'h0F0F_0F0F_0F0F_0000);
        set_src(0, 32'd7, 64'h7777_0000_0000_0000);
        req_val = 4'b0100;
        #1;
        chk("bp_grant", 64'(req_rdy), 64'd4);
        cyc();
        req_val = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("bp_hdr_val", 64'(noc_out_val), 64'd1);
            chk("bp_hdr_data", noc_out_data, hdr(8'd5, 8'd0));
            chk("bp_hdr_rdy0", 64'(req_rdy), 64'd0);
            cyc();
        end
        noc_out_rdy = 1'b1;
        cyc();
        noc_out_rdy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("bp_pld_val", 64'(noc_out_val), 64'd1);
            chk("bp_pld_data", noc_out_data, 64'h0F0F_0F0F_0F0F_0000);
            chk("bp_pld_rdy0", 64'(req_rdy), 64'd0);
            cyc();
        end

        // Reset while in PLD: packet abandoned, pointer back to src0
        req_val = 4'b1001;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("rstpld_val", 64'(noc_out_val), 64'd0);
        chk("rstpld_data", noc_out_data, 64'd0);
        chk("rstpld_pkt_cnt", 64'(pkt_cnt), 64'd0);
        chk("rstpld_grant", 64'(req_rdy), 64'd1);
        noc_out_rdy = 1'b1;
        cyc();
        req_val = '0;
        chk("rstpld_hdr", noc_out_data, hdr(8'd7, 8'd0));
        cyc();
        chk("rstpld_pld", noc_out_data, 64'h7777_0000_0000_0000);
        cyc();
        chk("rstpld_cnt1", 64'(pkt_cnt), 64'd1);

        // Packet counter saturation
        force dut.r_pkt_cnt = 16'hFFFE;
        #1;
        release dut.r_pkt_cnt;
        #1;
        chk("sat_start", 64'(pkt_cnt), 64'hFFFE);
        for (int i = 0; i < 3; i++) begin
            send(1);
            chk("sat_cnt", 64'(pkt_cnt), 64'hFFFF);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
